dm_responder: RTL and testbench

Data-memory responder serving the pipeline's Memory-stage load/store requests over a valid/ready request channel and a valid/ready response channel. It holds DEPTH 32-bit words, inserts LATENCY wait states per access, applies byte-lane writes and flags out-of-range addresses. It is the target end of the memory interface the CPU core drives, and lets the pipeline be tested against non-ideal (multi-cycle) memory.

---
 rtl/dm_responder.sv | 156 +++++++++++++++
 tb/tb_dm_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready load/store target with LATENCY wait states,
// byte-lane stores and out-of-range flagging. Optional store trace: DM_WRITE_LOG_EN.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | counting wait states down to zero
    // S_RESP | response presented, holding until resp_ready
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, oor_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic [31:0]         mem_q [DEPTH];
    logic [31:0]         rdata_q;
    logic                err_q;

    logic                in_idle, accept, enter_resp;
    logic                cur_we, cur_oor;
    logic [ADDR_W-1:0]   cur_idx;
    logic [31:0]         cur_wdata, old_word, merged;
    logic [3:0]          cur_be;
    logic                unused_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                cnt_d   = 4'(LATENCY);
                state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
    end

    assign in_idle    = (state_q == S_IDLE);
    assign accept     = in_idle && req_valid;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // With LATENCY=0 the commit happens on the accepting edge, so take the live inputs.
    assign cur_we    = in_idle ? req_we : we_q;
    assign cur_idx   = in_idle ? req_addr[ADDR_W+1:2] : idx_q;
    assign cur_oor   = in_idle ? (|(req_addr >> (ADDR_W + 2))) : oor_q;
    assign cur_wdata = in_idle ? req_wdata : wdata_q;
    assign cur_be    = in_idle ? req_be : be_q;
    assign old_word  = mem_q[cur_idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (accept) begin
            we_q    <= req_we;
            oor_q   <= |(req_addr >> (ADDR_W + 2));
            idx_q   <= req_addr[ADDR_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else if (enter_resp && cur_we && !cur_oor) begin
            mem_q[cur_idx] <= merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= cur_oor ? 32'd0 : (cur_we ? merged : old_word);
            err_q   <= cur_oor;
        end else if (state_q == S_RESP && resp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef DM_WRITE_LOG_EN
    logic [31:0] pc_q, cur_pc, log_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       pc_q <= 32'd0;
        else if (accept) pc_q <= req_pc;
    end

    assign cur_pc      = in_idle ? req_pc : pc_q;
    assign log_addr    = 32'(cur_idx) << 2;
    assign unused_bits = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_we && !cur_oor && cur_be != 4'd0)
            $display("%0t@%08h: *%08h <= %08h", $time, cur_pc, log_addr, merged);
    end
`else
    assign unused_bits = ^{req_pc, req_addr[1:0]};
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: LATENCY=2 instance for the main scenarios,
// LATENCY=0 instance for back-to-back throughput.
module tb_dm_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_req_valid = 0, a_req_ready, a_req_we = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_req_pc = 0;
    logic [3:0]  a_req_be = 0;
    logic        a_resp_valid, a_resp_ready = 1, a_resp_err;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid = 0, b_req_ready, b_req_we = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_req_pc = 0;
    logic [3:0]  b_req_be = 0;
    logic        b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    dm_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be), .req_pc(a_req_pc),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dm_responder #(.ADDR_W(10), .LATENCY(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be), .req_pc(b_req_pc),
        .resp_valid(b_resp_valid), .resp_ready(1'b1),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request to dut_a (called 1 time unit after an edge, dut_a idle).
    // Returns the response and the number of edges from acceptance to resp_valid
    // (-1 on timeout). Completes the handshake only if a_resp_ready is high.
    task automatic acc_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat);
        int acc, n;
        a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        a_req_be = be; a_req_pc = 32'h0000_4000 + addr;
        @(posedge clk); #1;
        a_req_valid = 0;
        acc = cyc;
        n = 0;
        while (!a_resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = a_resp_valid ? (cyc - acc) : -1;
        rd  = a_resp_rdata;
        er  = a_resp_err;
        if (a_resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [3:0]  vpat;
        logic [31:0] rd0, rd2;
        logic        stray;

        #2;
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_resp_rdata", a_resp_rdata, 0);
        chk("rst_resp_err", a_resp_err, 0);
        #10 reset = 0;
        @(posedge clk); #1;

        // store then load, latency 2
        acc_a(1, 32'h10, 32'h1234_5678, 4'hF, rd, er, lat);
        chk("st_lat", lat, 2);
        chk("st_rdata", rd, 32'h1234_5678);
        chk("st_err", er, 0);
        chk("post_hs_valid", a_resp_valid, 0);
        chk("post_hs_rdata", a_resp_rdata, 0);
        acc_a(0, 32'h10, 0, 4'h0, rd, er, lat);
        chk("ld_lat", lat, 2);
        chk("ld_rdata", rd, 32'h1234_5678);
        chk("ld_err", er, 0);
        acc_a(0, 32'h13, 0, 4'h0, rd, er, lat);
        chk("ld_unaligned", rd, 32'h1234_5678);

        // byte lanes
        acc_a(1, 32'h0, 32'hAABB_CCDD, 4'hF, rd, er, lat);
        acc_a(1, 32'h0, 32'h1122_3344, 4'b0101, rd, er, lat);
        chk("lane_st_rdata", rd, 32'hAA22_CC44);
        acc_a(0, 32'h0, 0, 4'h0, rd, er, lat);
        chk("lane_ld_rdata", rd, 32'hAA22_CC44);
        acc_a(1, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("be0_st_rdata", rd, 32'h1234_5678);

        // backpressure
        a_resp_ready = 0;
        acc_a(1, 32'h20, 32'h0000_0055, 4'hF, rd, er, lat);
        chk("bp_first_rdata", rd, 32'h0000_0055);
        a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'h66; a_req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", a_resp_valid, 1);
            chk("bp_rdata", a_resp_rdata, 32'h0000_0055);
            chk("bp_req_ready", a_req_ready, 0);
        end
        a_req_valid = 0;
        a_resp_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", a_resp_valid, 0);
        acc_a(0, 32'h20, 0, 4'h0, rd, er, lat);
        chk("bp_single_access", rd, 32'h0000_0055);

        // out of range and top in-range word
        acc_a(1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        chk("oor_err", er, 1);
        chk("oor_rdata", rd, 0);
        acc_a(0, 32'h0, 0, 4'h0, rd, er, lat);
        chk("oor_no_write", rd, 32'hAA22_CC44);
        acc_a(0, 32'h8000_0000, 0, 4'h0, rd, er, lat);
        chk("oor_ld_err", er, 1);
        acc_a(1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, rd, er, lat);
        chk("top_st_err", er, 0);
        acc_a(0, 32'h0000_0FFC, 0, 4'h0, rd, er, lat);
        chk("top_ld_rdata", rd, 32'h0BAD_CAFE);

        // reset while in WAIT
        a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h40; a_req_wdata = 32'hDEAD_BEEF; a_req_be = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 0;
        chk("wait_req_ready", a_req_ready, 0);
        #2 reset = 1;
        #1;
        chk("midrst_req_ready", a_req_ready, 1);
        chk("midrst_resp_valid", a_resp_valid, 0);
        @(posedge clk); #1;
        reset = 0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            stray = stray | a_resp_valid;
        end
        chk("midrst_no_resp", stray, 0);
        acc_a(0, 32'h40, 0, 4'h0, rd, er, lat);
        chk("midrst_ld_rdata", rd, 0);

        // latency 0 instance
        b_req_valid = 1; b_req_we = 1; b_req_addr = 32'h4; b_req_wdata = 32'hCAFE_F00D; b_req_be = 4'hF;
        @(posedge clk); #1;
        b_req_valid = 0;
        chk("l0_st_valid", b_resp_valid, 1);
        chk("l0_st_rdata", b_resp_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("l0_hs_valid", b_resp_valid, 0);
        b_req_valid = 1; b_req_we = 0;
        vpat = 4'd0; rd0 = 0; rd2 = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            vpat[k] = b_resp_valid;
            if (k == 0) rd0 = b_resp_rdata;
            if (k == 2) rd2 = b_resp_rdata;
        end
        b_req_valid = 0;
        chk("l0_b2b_pattern", vpat, 4'b0101);
        chk("l0_ld0_rdata", rd0, 32'hCAFE_F00D);
        chk("l0_ld1_rdata", rd2, 32'hCAFE_F00D);
        chk("l0_ld_err", b_resp_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
